// File: rtl/tcm_axi_pkg.sv
// Shared types and constants for the TCM AXI slave request/response trackers.
package tcm_axi_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/tcm_axi_burst_tracker_if.sv
// AXI4 AW/W/AR request-side handshake bundle seen by the TCM burst tracker.
interface tcm_axi_burst_tracker_if
  import tcm_axi_pkg::*;
#(
  parameter int unsigned ID_W  = AXI_ID_W,
  parameter int unsigned LEN_W = AXI_LEN_W
);

  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;
  logic [1:0]        awburst;
  logic              awready;

  logic              wvalid;
  logic              wready;

  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;
  logic [1:0]        arburst;
  logic              arready;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst,
    output wvalid,
    output arvalid, araddr, arid, arlen, arburst,
    input  awready, wready, arready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst,
    input  wvalid,
    input  arvalid, araddr, arid, arlen, arburst,
    output awready, wready, arready
  );

endinterface

// File: rtl/tcm_axi_addr_next.sv
// Next beat address for FIXED/INCR/WRAP bursts of 4-byte beats.
module tcm_axi_addr_next
  import tcm_axi_pkg::*;
#(
  parameter int unsigned LEN_W = AXI_LEN_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_c_o
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  // Illegal WRAP lengths and the reserved burst code fall back to INCR
  always_comb begin
    incr_addr = addr_i + ADDR_W'(BEAT_BYTES);
    wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) * ADDR_W'(BEAT_BYTES)) - ADDR_W'(1);
    wrap_ok   = (len_i == LEN_W'(1)) || (len_i == LEN_W'(3)) ||
                (len_i == LEN_W'(7)) || (len_i == LEN_W'(15));
    case (burst_i)
      FIXED:   next_addr_c_o = addr_i;
      WRAP:    next_addr_c_o = wrap_ok ? ((addr_i & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
      default: next_addr_c_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/tcm_axi_burst_tracker.sv
// AXI4 slave request tracker for the single-port TCM: arbitrates AW/AR and
// walks one burst at a time, presenting per-beat address and direction.
module tcm_axi_burst_tracker
  import tcm_axi_pkg::*;
#(
  parameter int unsigned ID_W  = AXI_ID_W,
  parameter int unsigned LEN_W = AXI_LEN_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tcm_axi_burst_tracker_if.slave  axi,
  input  logic                    mem_ready_i,
  output logic                    req_wr_q_o,
  output logic                    req_rd_q_o,
  output logic [ADDR_W-1:0]       req_addr_q_o,
  output logic [ID_W-1:0]         req_id_o,
  output logic                    req_last_o,
  output logic                    write_active_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              last_q, last_d;
  logic              last_grant_wr_q, last_grant_wr_d;

  logic              idle;
  logic              write_active;
  logic              beat_fire;
  logic [ADDR_W-1:0] next_addr;

  tcm_axi_addr_next #(.LEN_W(LEN_W)) u_addr_next (
    .addr_i        (addr_q),
    .len_i         (len_q),
    .burst_i       (burst_q),
    .next_addr_c_o (next_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      id_q            <= '0;
      len_q           <= '0;
      burst_q         <= '0;
      remaining_q     <= '0;
      last_q          <= 1'b0;
      last_grant_wr_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      id_q            <= id_d;
      len_q           <= len_d;
      burst_q         <= burst_d;
      remaining_q     <= remaining_d;
      last_q          <= last_d;
      last_grant_wr_q <= last_grant_wr_d;
    end
  end

  // Round-robin grant on a tie: write wins unless it was granted last
  assign idle         = (state_q == IDLE);
  assign write_active = idle & axi.awvalid & (~axi.arvalid | ~last_grant_wr_q);
  assign beat_fire    = ((state_q == WRITE) & axi.wvalid & mem_ready_i) |
                        ((state_q == READ) & mem_ready_i);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    id_d            = id_q;
    len_d           = len_q;
    burst_d         = burst_q;
    remaining_d     = remaining_q;
    last_d          = last_q;
    last_grant_wr_d = last_grant_wr_q;

    case (state_q)
      IDLE: begin
        if (write_active) begin
          state_d         = WRITE;
          addr_d          = axi.awaddr & ~ADDR_W'(BEAT_BYTES - 1);
          id_d            = axi.awid;
          len_d           = axi.awlen;
          burst_d         = axi.awburst;
          remaining_d     = axi.awlen;
          last_d          = (axi.awlen == '0);
          last_grant_wr_d = 1'b1;
        end else if (axi.arvalid) begin
          state_d         = READ;
          addr_d          = axi.araddr & ~ADDR_W'(BEAT_BYTES - 1);
          id_d            = axi.arid;
          len_d           = axi.arlen;
          burst_d         = axi.arburst;
          remaining_d     = axi.arlen;
          last_d          = (axi.arlen == '0);
          last_grant_wr_d = 1'b0;
        end
      end
      WRITE, READ: begin
        if (beat_fire) begin
          if (remaining_q == '0) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            addr_d      = next_addr;
            last_d      = (remaining_q == LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.awready    = write_active;
  assign axi.arready    = idle & axi.arvalid & ~write_active;
  assign axi.wready     = (state_q == WRITE) & mem_ready_i;
  assign write_active_o = write_active;
  assign req_wr_q_o     = (state_q == WRITE);
  assign req_rd_q_o     = (state_q == READ);
  assign req_addr_q_o   = addr_q;
  assign req_id_o       = id_q;
  assign req_last_o     = last_q;

endmodule

// File: tb/tb_tcm_axi_burst_tracker.sv
// Scoreboard bench for tcm_axi_burst_tracker: expected beats are queued at
// request time and retired by a negedge monitor whenever a beat fires.
module tb_tcm_axi_burst_tracker;
  import tcm_axi_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_ready;
  logic        req_wr, req_rd, req_last, write_active;
  logic [31:0] req_addr;
  logic [3:0]  req_id;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t mon_got, mon_exp;

  tcm_axi_burst_tracker_if #(.ID_W(4), .LEN_W(8)) axi ();

  tcm_axi_burst_tracker #(.ID_W(4), .LEN_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .axi            (axi),
    .mem_ready_i    (mem_ready),
    .req_wr_q_o     (req_wr),
    .req_rd_q_o     (req_rd),
    .req_addr_q_o   (req_addr),
    .req_id_o       (req_id),
    .req_last_o     (req_last),
    .write_active_o (write_active)
  );

  always #5 clk = ~clk;

  // Beat monitor: retire one scoreboard entry per fired beat
  always @(negedge clk) begin
    if (!rst_i) begin
      checks++;
      if ((req_wr && req_rd) || (axi.awready && axi.arready)) begin
        errors++;
        $display("FAIL exclusive: wr=%0b rd=%0b awready=%0b arready=%0b, required pairs not both 1",
                 req_wr, req_rd, axi.awready, axi.arready);
      end
      if ((req_wr && axi.wvalid && mem_ready) || (req_rd && mem_ready)) begin
        checks++;
        mon_got.wr = req_wr; mon_got.addr = req_addr;
        mon_got.last = req_last; mon_got.id = req_id;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got wr=%0b addr=%h last=%0b id=%0h, required no beat",
                   mon_got.wr, mon_got.addr, mon_got.last, mon_got.id);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL beat: got wr=%0b addr=%h last=%0b id=%0h, required wr=%0b addr=%h last=%0b id=%0h",
                     mon_got.wr, mon_got.addr, mon_got.last, mon_got.id,
                     mon_exp.wr, mon_exp.addr, mon_exp.last, mon_exp.id);
          end
        end
      end
    end
  end

  task automatic push(input logic wr, input logic [31:0] a, input logic last, input logic [3:0] id);
    beat_t b;
    b.wr = wr; b.addr = a; b.last = last; b.id = id;
    exp_q.push_back(b);
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] id);
    axi.awvalid = 1'b1; axi.awaddr = a; axi.awlen = l; axi.awburst = b; axi.awid = id;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] id);
    axi.arvalid = 1'b1; axi.araddr = a; axi.arlen = l; axi.arburst = b; axi.arid = id;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; mem_ready = 1'b1; axi.wvalid = 1'b1;
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awid = '0;
    axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arid = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    checks++; if ({req_wr, req_rd, req_last} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got wr/rd/last=%b, required 000", {req_wr, req_rd, req_last}); end
    checks++; if (req_addr !== 32'h0) begin errors++;
      $display("FAIL reset_addr: got %h, required 00000000", req_addr); end
    checks++; if (req_id !== 4'h0) begin errors++;
      $display("FAIL reset_id: got %h, required 0", req_id); end
    checks++; if ({axi.awready, axi.arready, write_active} !== 3'b000) begin errors++;
      $display("FAIL reset_ready: got aw/ar/wa=%b, required 000", {axi.awready, axi.arready, write_active}); end
    @(posedge clk); #2;
    checks++; if (axi.wready !== 1'b0) begin errors++;
      $display("FAIL idle_wready: got %b with wvalid in IDLE, required 0", axi.wready); end
  endtask

  task automatic test_arbitration;
    @(posedge clk); #1;
    drive_aw(32'h40, 8'd0, 2'd1, 4'h1);
    drive_ar(32'h80, 8'd0, 2'd1, 4'h2);
    push(1'b1, 32'h40, 1'b1, 4'h1);
    #1;
    checks++; if ({axi.awready, axi.arready, write_active} !== 3'b101) begin errors++;
      $display("FAIL arb_first: got aw/ar/wa=%b, required 101", {axi.awready, axi.arready, write_active}); end
    @(posedge clk); #2;
    checks++; if ({req_wr, axi.awready, axi.arready} !== 3'b100) begin errors++;
      $display("FAIL arb_busy: got wr/aw/ar=%b, required 100", {req_wr, axi.awready, axi.arready}); end
    @(posedge clk); #2;
    checks++; if ({axi.awready, axi.arready, write_active} !== 3'b010) begin errors++;
      $display("FAIL arb_second: got aw/ar/wa=%b, required 010", {axi.awready, axi.arready, write_active}); end
    push(1'b0, 32'h80, 1'b1, 4'h2);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL arb_timeout: %0d beats outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_incr;
    @(posedge clk); #1;
    drive_aw(32'h100, 8'd3, 2'd1, 4'h5);
    axi.wvalid = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h100 + 32'(4 * i), (i == 3), 4'h5);
    @(posedge clk); #1 axi.awvalid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL incr_timeout: %0d beats outstanding, required 0", exp_q.size()); exp_q.delete(); end
    checks++; if ({req_wr, req_rd, req_last} !== 3'b000) begin errors++;
      $display("FAIL incr_idle: got wr/rd/last=%b, required 000", {req_wr, req_rd, req_last}); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h138, 32'h13C, 32'h130, 32'h134};
    @(posedge clk); #1;
    drive_ar(32'h138, 8'd3, 2'd2, 4'h3);
    axi.wvalid = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, exp_addr[i], (i == 3), 4'h3);
    @(posedge clk); #1 axi.arvalid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL wrap_timeout: %0d beats outstanding, required 0", exp_q.size()); exp_q.delete(); end
    checks++; if (req_rd !== 1'b0) begin errors++;
      $display("FAIL wrap_idle: got req_rd=%b, required 0", req_rd); end
  endtask

  task automatic test_boundary;
    @(posedge clk); #1;
    drive_aw(32'hFFFF_FFFC, 8'd1, 2'd1, 4'h7);
    axi.wvalid = 1'b1; mem_ready = 1'b1;
    push(1'b1, 32'hFFFF_FFFC, 1'b0, 4'h7);
    push(1'b1, 32'h0000_0000, 1'b1, 4'h7);
    @(posedge clk); #1 axi.awvalid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL rollover_timeout: %0d beats outstanding, required 0", exp_q.size()); exp_q.delete(); end
    @(posedge clk); #1;
    drive_ar(32'h23, 8'd2, 2'd0, 4'h9);
    for (int i = 0; i < 3; i++) push(1'b0, 32'h20, (i == 2), 4'h9);
    @(posedge clk); #1 axi.arvalid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL fixed_timeout: %0d beats outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall;
    int          pulses;
    logic [31:0] prev_addr;
    logic        prev_ready, have_prev;
    pulses = 0; have_prev = 1'b0; prev_ready = 1'b1; prev_addr = '0;
    @(posedge clk); #1;
    drive_aw(32'h200, 8'd7, 2'd1, 4'hA);
    axi.wvalid = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, 32'h200 + 32'(4 * i), (i == 7), 4'hA);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      mem_ready = (i % 2 == 0);
      #1;
      if (axi.wready) pulses++;
      if (have_prev && req_wr && !prev_ready) begin
        checks++; if (req_addr !== prev_addr) begin errors++;
          $display("FAIL stall_addr: got %h after mem_ready=0, required %h", req_addr, prev_addr); end
      end
      prev_addr = req_addr; prev_ready = mem_ready; have_prev = req_wr;
    end
    mem_ready = 1'b1;
    checks++; if (pulses != 8) begin errors++;
      $display("FAIL stall_pulses: got %0d wready pulses, required 8", pulses); end
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL stall_timeout: %0d beats outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    drive_aw(32'h300, 8'd7, 2'd1, 4'h4);
    axi.wvalid = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, 32'h300 + 32'(4 * i), (i == 7), 4'h4);
    @(posedge clk); #1 axi.awvalid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 4; i++) @(posedge clk);
    checks++; if (exp_q.size() != 4) begin errors++;
      $display("FAIL midrst_progress: %0d beats outstanding, required 4", exp_q.size()); end
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    checks++; if ({req_wr, req_rd, req_last} !== 3'b000) begin errors++;
      $display("FAIL midrst_flags: got wr/rd/last=%b, required 000", {req_wr, req_rd, req_last}); end
    checks++; if (req_addr !== 32'h0) begin errors++;
      $display("FAIL midrst_addr: got %h, required 00000000", req_addr); end
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_wr !== 1'b0) begin errors++;
      $display("FAIL midrst_stay_idle: got req_wr=%b, required 0", req_wr); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_incr();
    test_wrap();
    test_boundary();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
